// File: rtl/log_normalizer_if.sv
// Handshake bus of the log normalizer: number/log pair in, mantissa/exponent result out.
interface log_normalizer_if #(
   parameter int W  = 8,
   parameter int LW = 3,
   parameter int CW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_number;
   logic [LW-1:0] in_log;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_mant;
   logic [LW-1:0] out_exp;
   logic          out_zero;
   logic          out_err;
   logic [CW-1:0] out_count;

   modport slave (
      input  in_valid, in_number, in_log, out_ready,
      output in_ready, out_valid, out_mant, out_exp, out_zero, out_err, out_count
   );

   modport master (
      output in_valid, in_number, in_log, out_ready,
      input  in_ready, out_valid, out_mant, out_exp, out_zero, out_err, out_count
   );
endinterface

// File: rtl/log_normalizer.sv
// Two-stage valid/ready normalizer: left-justifies a number using its MSB index, counts results.
// Optional consistency check of the supplied log is enabled with `define LOG_NORM_CHECK_EN.
module log_normalizer #(
   parameter int W  = 8,
   parameter int LW = 3,
   parameter int CW = 16
) (
   input logic             clk,
   input logic             rst,
   log_normalizer_if.slave bus
);

   logic          s1_valid_q, s1_valid_d;
   logic [W-1:0]  s1_number_q;
   logic [LW-1:0] s1_log_q;
   logic          s2_valid_q, s2_valid_d;
   logic [W-1:0]  s2_mant_q, s2_mant_d;
   logic [LW-1:0] s2_exp_q;
   logic          s2_zero_q, s2_zero_d;
   logic          s2_err_q, s2_err_d;
   logic [CW-1:0] count_q, count_d;

   logic          s2_adv;
   logic          in_fire;
   logic          out_fire;
   logic [LW-1:0] shamt;

   assign s2_adv   = s1_valid_q && (!s2_valid_q || bus.out_ready);
   assign bus.in_ready = !s1_valid_q || s2_adv;
   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = s2_valid_q && bus.out_ready;
   assign shamt    = LW'(W - 1) - s1_log_q;

`ifdef LOG_NORM_CHECK_EN
   function automatic logic [LW-1:0] msb_idx(input logic [W-1:0] n);
      logic [LW-1:0] idx;
      idx = '0;
      for (int i = 0; i < W; i++) begin
         if (n[i]) idx = LW'(i);
      end
      return idx;
   endfunction
`endif

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (in_fire)     s1_valid_d = 1'b1;
      else if (s2_adv) s1_valid_d = 1'b0;

      s2_valid_d = s2_valid_q;
      if (s2_adv)        s2_valid_d = 1'b1;
      else if (out_fire) s2_valid_d = 1'b0;

      s2_mant_d = s1_number_q << shamt;
      s2_zero_d = (s1_number_q == '0);
`ifdef LOG_NORM_CHECK_EN
      // Flags the mismatch only; mantissa/exponent still follow the supplied log.
      s2_err_d = s2_zero_d ? (s1_log_q != '0) : (msb_idx(s1_number_q) != s1_log_q);
`else
      s2_err_d = 1'b0;
`endif

      count_d = count_q + {{(CW-1){1'b0}}, out_fire};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_number_q <= '0;
         s1_log_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_mant_q   <= '0;
         s2_exp_q    <= '0;
         s2_zero_q   <= 1'b0;
         s2_err_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         count_q    <= count_d;
         if (in_fire) begin
            s1_number_q <= bus.in_number;
            s1_log_q    <= bus.in_log;
         end
         if (s2_adv) begin
            s2_mant_q <= s2_mant_d;
            s2_exp_q  <= s1_log_q;
            s2_zero_q <= s2_zero_d;
            s2_err_q  <= s2_err_d;
         end
      end
   end

   assign bus.out_valid = s2_valid_q;
   assign bus.out_mant  = s2_mant_q;
   assign bus.out_exp   = s2_exp_q;
   assign bus.out_zero  = s2_zero_q;
   assign bus.out_err   = s2_err_q;
   assign bus.out_count = count_q;

endmodule

// File: tb/tb_log_normalizer.sv
// Bench for log_normalizer: directed steps plus random traffic against a queue-based model.
module tb_log_normalizer;

   logic clk;
   logic rst;

   log_normalizer_if #(.W(8), .LW(3), .CW(16)) bus  ();
   log_normalizer_if #(.W(8), .LW(3), .CW(4))  bus4 ();

   log_normalizer #(.W(8), .LW(3), .CW(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
   log_normalizer #(.W(8), .LW(3), .CW(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

   assign bus4.in_valid  = bus.in_valid;
   assign bus4.in_number = bus.in_number;
   assign bus4.in_log    = bus.in_log;
   assign bus4.out_ready = bus.out_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] mant;
      logic [2:0] e;
      logic       z;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cnt      = 0;
   bit   last_acc;
   bit   last_con;
   bit   hold_vld = 0;

   function automatic exp_t model(input logic [7:0] n, input logic [2:0] l);
      exp_t r;
      int   full;
      int   msb;
      full   = int'(n) * (1 << (7 - int'(l)));
      r.mant = 8'(full % 256);
      r.e    = l;
      r.z    = (n == 8'h00);
      msb    = (n == 8'h00) ? 0 : $clog2(int'(n) + 1) - 1;
`ifdef LOG_NORM_CHECK_EN
      r.err  = (n == 8'h00) ? (l != 3'd0) : (msb != int'(l));
`else
      r.err  = 1'b0;
`endif
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // One clock: drive at posedge+1, check at negedge, update model, return at next posedge+1.
   task automatic cycle(input bit v, input logic [7:0] n, input logic [2:0] l, input bit ordy);
      int occ;
      bus.in_valid  = v;
      bus.in_number = n;
      bus.in_log    = l;
      bus.out_ready = ordy;
      @(negedge clk);
      occ = q.size();
      chk("in_ready", {31'd0, bus.in_ready}, (occ < 2) ? 32'd1 : {31'd0, ordy});
      if (occ == 0) chk("idle_valid", {31'd0, bus.out_valid}, 32'd0);
      if (hold_vld) chk("held_valid", {31'd0, bus.out_valid}, 32'd1);
      if (bus.out_valid) begin
         if (occ == 0) begin
            chk("spurious_valid", {31'd0, bus.out_valid}, 32'd0);
         end else begin
            chk("mant", {24'd0, bus.out_mant}, {24'd0, q[0].mant});
            chk("exp",  {29'd0, bus.out_exp},  {29'd0, q[0].e});
            chk("zero", {31'd0, bus.out_zero}, {31'd0, q[0].z});
            chk("err",  {31'd0, bus.out_err},  {31'd0, q[0].err});
         end
      end
      last_acc = v && bus.in_ready;
      last_con = bus.out_valid && ordy;
      hold_vld = bus.out_valid && !ordy;
      if (last_con && occ > 0) void'(q.pop_front());
      if (last_acc) q.push_back(model(n, l));
      if (last_con) cnt++;
      @(posedge clk);
      #1;
      chk("count16", {16'd0, bus.out_count}, 32'(cnt % 65536));
      chk("count4",  {28'd0, bus4.out_count}, 32'(cnt % 16));
   endtask

   task automatic send(input logic [7:0] n, input logic [2:0] l, input bit ordy);
      int tries = 0;
      do begin
         cycle(1'b1, n, l, ordy);
         tries++;
      end while (!last_acc && tries < 50);
      if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() > 0 && k < 50) begin
         cycle(1'b0, 8'h00, 3'd0, 1'b1);
         k++;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_count", {16'd0, bus.out_count}, 32'd0);
      chk("rst_count4", {28'd0, bus4.out_count}, 32'd0);
      q.delete();
      cnt      = 0;
      hold_vld = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_number = 8'h00;
      bus.in_log    = 3'd0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_mant",  {24'd0, bus.out_mant},  32'd0);
      chk("rst_out_exp",   {29'd0, bus.out_exp},   32'd0);
      chk("rst_out_zero",  {31'd0, bus.out_zero},  32'd0);
      chk("rst_out_err",   {31'd0, bus.out_err},   32'd0);
      chk("rst_out_count", {16'd0, bus.out_count}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // First item latency and value.
      cycle(1'b1, 8'h01, 3'd0, 1'b1);
      chk("lat_not_yet", {31'd0, bus.out_valid}, 32'd0);
      cycle(1'b0, 8'h00, 3'd0, 1'b1);
      chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("lat_mant",  {24'd0, bus.out_mant},  32'h80);
      cycle(1'b0, 8'h00, 3'd0, 1'b1);
      chk("first_count", {16'd0, bus.out_count}, 32'd1);

      // Back-to-back stream.
      cycle(1'b1, 8'h80, 3'd7, 1'b1); chk("b2b_acc0", {31'd0, last_acc}, 32'd1);
      cycle(1'b1, 8'h13, 3'd4, 1'b1); chk("b2b_acc1", {31'd0, last_acc}, 32'd1);
      cycle(1'b1, 8'h00, 3'd0, 1'b1); chk("b2b_acc2", {31'd0, last_acc}, 32'd1); chk("b2b_con0", {31'd0, last_con}, 32'd1);
      cycle(1'b1, 8'h3F, 3'd5, 1'b1); chk("b2b_acc3", {31'd0, last_acc}, 32'd1); chk("b2b_con1", {31'd0, last_con}, 32'd1);
      cycle(1'b0, 8'h00, 3'd0, 1'b1); chk("b2b_con2", {31'd0, last_con}, 32'd1);
      cycle(1'b0, 8'h00, 3'd0, 1'b1); chk("b2b_con3", {31'd0, last_con}, 32'd1);
      drain();

      // Backpressure: third item must wait until the output is released.
      send(8'h05, 3'd2, 1'b0);
      send(8'hC0, 3'd7, 1'b0);
      repeat (3) begin
         cycle(1'b1, 8'h0A, 3'd3, 1'b0);
         chk("bp_blocked", {31'd0, last_acc}, 32'd0);
      end
      send(8'h0A, 3'd3, 1'b1);
      drain();
      chk("bp_count", {16'd0, bus.out_count}, 32'd5 + 32'd3);

      // Log check pairs (err expectation follows the build).
      send(8'h20, 3'd3, 1'b1);
      send(8'h20, 3'd5, 1'b1);
      drain();

      // Reset with two items in flight.
      send(8'h11, 3'd4, 1'b0);
      send(8'h22, 3'd5, 1'b0);
      do_reset();
      repeat (4) cycle(1'b0, 8'h00, 3'd0, 1'b1);

      // Counter wrap on the 4-bit instance.
      repeat (17) send(8'h01, 3'd0, 1'b1);
      drain();
      chk("wrap4",  {28'd0, bus4.out_count}, 32'd1);
      chk("wrap16", {16'd0, bus.out_count},  32'd17);

      // Random traffic, mostly consistent logs.
      for (int i = 0; i < 400; i++) begin
         logic [7:0] n;
         logic [2:0] l;
         n = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0)
            l = (n == 8'h00) ? 3'd0 : 3'($clog2(int'(n) + 1) - 1);
         else
            l = 3'($urandom_range(0, 7));
         cycle(1'($urandom_range(0, 1)), n, l, ($urandom_range(0, 3) != 0));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
